// File: rtl/iq_issue_pkg.sv
// Shared types for the instruction queue / issue stage: opcode, queue entry and FSM state.
package tomasula_types;

    typedef enum logic [2:0] {
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_LD, OP_ST, OP_BRANCH, OP_NOP
    } op_t;

    typedef struct packed {
        op_t         op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [31:0] pc;
        logic        pred_taken;
    } iq_entry_t;

    typedef enum logic {RUN, FLUSH} iq_state_t;

    function automatic logic is_mem_op(op_t op);
        return (op == OP_LD) || (op == OP_ST);
    endfunction

endpackage

// File: rtl/iq_issue_fifo.sv
// Circular buffer of decoded instructions. The caller never pushes when full or pops when empty.
module iq_fifo
    import tomasula_types::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       clear,
    input  iq_entry_t                  din,
    output iq_entry_t                  dout,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    iq_entry_t     mem [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (clear) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            // Pointers are exactly log2(DEPTH) bits, so they wrap for free.
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push && !clear) mem[tail] <= din;
    end

    assign dout = mem[head];

endmodule

// File: rtl/iq_issue.sv
// In-order instruction queue and issue stage: allocates a ROB entry and loads the ALU RS or LSQ.
module iq_issue
    import tomasula_types::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enq_valid,
    output logic                       enq_ready,
    input  op_t                        enq_op,
    input  logic [4:0]                 enq_rd,
    input  logic [4:0]                 enq_rs1,
    input  logic [4:0]                 enq_rs2,
    input  logic [31:0]                enq_imm,
    input  logic [31:0]                enq_pc,
    input  logic                       enq_pred_taken,
    input  logic                       rob_full,
    input  logic [2:0]                 rob_curr_ptr,
    input  logic                       ld_pc,
    input  logic                       flush_in_prog,
    input  logic                       br_commit,
    input  logic                       alu_rs_full,
    input  logic                       lsq_full,
    output logic                       rob_load,
    output op_t                        instr_type,
    output logic [4:0]                 rd,
    output logic [4:0]                 st_src,
    output logic                       rs_load_alu,
    output logic                       rs_load_lsq,
    output logic [4:0]                 iss_rs1,
    output logic [4:0]                 iss_rs2,
    output logic [31:0]                iss_imm,
    output logic [31:0]                iss_pc,
    output logic [2:0]                 iss_tag,
    output logic [$clog2(DEPTH+1)-1:0] iq_count
);

    localparam int CW = $clog2(DEPTH+1);

    iq_state_t state;
    iq_state_t state_next;
    logic      br_outstanding;
    iq_entry_t enq_entry;
    iq_entry_t head_entry;
    logic      push;
    logic      can_issue;
    logic      rs_busy;
    logic      br_block;

    assign enq_entry = '{op: enq_op, rd: enq_rd, rs1: enq_rs1, rs2: enq_rs2,
                         imm: enq_imm, pc: enq_pc, pred_taken: enq_pred_taken};

    assign enq_ready = (iq_count != CW'(DEPTH)) && (state == RUN) && !ld_pc;
    assign push      = enq_valid && enq_ready;

    assign rs_busy   = is_mem_op(head_entry.op) ? lsq_full : alu_rs_full;
    assign br_block  = (head_entry.op == OP_BRANCH) && br_outstanding;
    assign can_issue = (iq_count != '0) && (state == RUN) && !ld_pc && !flush_in_prog
                       && !rob_full && !rs_busy && !br_block;

    iq_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (can_issue),
        .clear (ld_pc),
        .din   (enq_entry),
        .dout  (head_entry),
        .count (iq_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= RUN;
            br_outstanding <= 1'b0;
        end else begin
            state <= state_next;
            // A branch issuing in the same cycle as a commit keeps the flag set.
            if (ld_pc)
                br_outstanding <= 1'b0;
            else if (can_issue && head_entry.op == OP_BRANCH)
                br_outstanding <= 1'b1;
            else if (br_commit)
                br_outstanding <= 1'b0;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            RUN:     if (ld_pc) state_next = FLUSH;
            FLUSH:   if (!ld_pc && !flush_in_prog) state_next = RUN;
            default: state_next = RUN;
        endcase
    end

    always_comb begin
        rob_load    = 1'b0;
        rs_load_alu = 1'b0;
        rs_load_lsq = 1'b0;
        instr_type  = OP_ADD;
        rd          = '0;
        st_src      = '0;
        iss_rs1     = '0;
        iss_rs2     = '0;
        iss_imm     = '0;
        iss_pc      = '0;
        iss_tag     = '0;
        if (can_issue) begin
            rob_load    = 1'b1;
            rs_load_lsq = is_mem_op(head_entry.op);
            rs_load_alu = !is_mem_op(head_entry.op);
            instr_type  = head_entry.op;
            iss_rs1     = head_entry.rs1;
            iss_rs2     = head_entry.rs2;
            iss_imm     = head_entry.imm;
            iss_pc      = head_entry.pc;
            iss_tag     = rob_curr_ptr;
            // Branch rd carries the prediction in bit 1; the ROB fills bit 0 on resolve.
            case (head_entry.op)
                OP_ST: begin
                    rd     = '0;
                    st_src = head_entry.rs2;
                end
                OP_BRANCH: rd = {3'b000, head_entry.pred_taken, 1'b0};
                default:   rd = head_entry.rd;
            endcase
        end
    end

endmodule

// File: tb/tb_iq_issue.sv
// Directed and randomized bench for iq_issue with a queue-based scoreboard of expected issues.
module tb_iq_issue;
    import tomasula_types::*;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enq_valid = 1'b0;
    logic        enq_ready;
    op_t         enq_op = OP_ADD;
    logic [4:0]  enq_rd = '0, enq_rs1 = '0, enq_rs2 = '0;
    logic [31:0] enq_imm = '0, enq_pc = '0;
    logic        enq_pred_taken = 1'b0;
    logic        rob_full = 1'b0;
    logic [2:0]  rob_curr_ptr = 3'd3;
    logic        ld_pc = 1'b0, flush_in_prog = 1'b0, br_commit = 1'b0;
    logic        alu_rs_full = 1'b0, lsq_full = 1'b0;
    logic        rob_load;
    op_t         instr_type;
    logic [4:0]  rd, st_src, iss_rs1, iss_rs2;
    logic        rs_load_alu, rs_load_lsq;
    logic [31:0] iss_imm, iss_pc;
    logic [2:0]  iss_tag;
    logic [3:0]  iq_count;

    int checks = 0;
    int errors = 0;
    iq_entry_t sb[$];
    logic m_run = 1'b1;
    logic m_br  = 1'b0;
    int seq = 0;

    iq_issue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .enq_valid(enq_valid), .enq_ready(enq_ready),
        .enq_op(enq_op), .enq_rd(enq_rd), .enq_rs1(enq_rs1), .enq_rs2(enq_rs2),
        .enq_imm(enq_imm), .enq_pc(enq_pc), .enq_pred_taken(enq_pred_taken),
        .rob_full(rob_full), .rob_curr_ptr(rob_curr_ptr), .ld_pc(ld_pc),
        .flush_in_prog(flush_in_prog), .br_commit(br_commit),
        .alu_rs_full(alu_rs_full), .lsq_full(lsq_full), .rob_load(rob_load),
        .instr_type(instr_type), .rd(rd), .st_src(st_src),
        .rs_load_alu(rs_load_alu), .rs_load_lsq(rs_load_lsq),
        .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .iss_imm(iss_imm), .iss_pc(iss_pc),
        .iss_tag(iss_tag), .iq_count(iq_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [4:0] exp_rd(input iq_entry_t e);
        if (e.op == OP_ST) return 5'd0;
        if (e.op == OP_BRANCH) return {3'b000, e.pred_taken, 1'b0};
        return e.rd;
    endfunction

    task automatic offer(input op_t op, input logic [4:0] r, input logic [4:0] s1,
                         input logic [4:0] s2, input logic pt);
        seq++;
        enq_valid = 1'b1; enq_op = op; enq_rd = r; enq_rs1 = s1; enq_rs2 = s2;
        enq_imm = 32'h1000 + 32'(seq); enq_pc = 32'h4000 + 32'(seq * 4); enq_pred_taken = pt;
    endtask

    // One clock: check issue outputs against the model at negedge, update the model, advance.
    task automatic tick();
        logic      exp_ready;
        logic      exp_issue;
        logic      accepted;
        iq_entry_t e;
        @(negedge clk);
        exp_ready = (sb.size() != DEPTH) && m_run && !ld_pc;
        chk("enq_ready", 32'(enq_ready), 32'(exp_ready));
        chk("iq_count", 32'(iq_count), 32'(sb.size()));
        exp_issue = 1'b0;
        e = '0;
        if (sb.size() != 0 && m_run && !ld_pc && !flush_in_prog && !rob_full) begin
            e = sb[0];
            exp_issue = !((e.op == OP_LD || e.op == OP_ST) ? lsq_full : alu_rs_full)
                        && !(e.op == OP_BRANCH && m_br);
        end
        chk("rob_load", 32'(rob_load), 32'(exp_issue));
        if (exp_issue) begin
            chk("instr_type", 32'(instr_type), 32'(e.op));
            chk("rd", 32'(rd), 32'(exp_rd(e)));
            chk("st_src", 32'(st_src), (e.op == OP_ST) ? 32'(e.rs2) : 32'd0);
            chk("iss_rs1", 32'(iss_rs1), 32'(e.rs1));
            chk("iss_rs2", 32'(iss_rs2), 32'(e.rs2));
            chk("iss_imm", iss_imm, e.imm);
            chk("iss_pc", iss_pc, e.pc);
            chk("iss_tag", 32'(iss_tag), 32'(rob_curr_ptr));
            chk("rs_load_lsq", 32'(rs_load_lsq), 32'(e.op == OP_LD || e.op == OP_ST));
            chk("rs_load_alu", 32'(rs_load_alu), 32'(!(e.op == OP_LD || e.op == OP_ST)));
        end else begin
            chk("idle_alu", 32'(rs_load_alu), 32'd0);
            chk("idle_lsq", 32'(rs_load_lsq), 32'd0);
            chk("idle_pc", iss_pc, 32'd0);
            chk("idle_rd", 32'(rd), 32'd0);
        end
        accepted = enq_valid && exp_ready;
        if (ld_pc) begin
            sb.delete();
            m_run = 1'b0;
            m_br  = 1'b0;
        end else begin
            if (exp_issue) void'(sb.pop_front());
            if (exp_issue && e.op == OP_BRANCH) m_br = 1'b1;
            else if (br_commit) m_br = 1'b0;
            if (accepted)
                sb.push_back('{op: enq_op, rd: enq_rd, rs1: enq_rs1, rs2: enq_rs2,
                               imm: enq_imm, pc: enq_pc, pred_taken: enq_pred_taken});
            if (!m_run && !flush_in_prog) m_run = 1'b1;
        end
        @(posedge clk);
        #1;
        rob_curr_ptr = rob_curr_ptr + 3'd1;
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_enq_ready", 32'(enq_ready), 32'd1);
        chk("rst_rob_load", 32'(rob_load), 32'd0);
        chk("rst_count", 32'(iq_count), 32'd0);
        chk("rst_alu", 32'(rs_load_alu), 32'd0);
        chk("rst_lsq", 32'(rs_load_lsq), 32'd0);
        chk("rst_pc", iss_pc, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Single ADD
        offer(OP_ADD, 5'd5, 5'd1, 5'd2, 1'b0);
        tick();
        enq_valid = 1'b0;
        tick();
        chk("t1_count", 32'(iq_count), 32'd0);

        // Store held by a full LSQ
        lsq_full = 1'b1;
        offer(OP_ST, 5'd9, 5'd3, 5'd7, 1'b0);
        tick();
        enq_valid = 1'b0;
        repeat (3) tick();
        lsq_full = 1'b0;
        tick();

        // Fill behind a full ROB, then drain with concurrent pushes
        rob_full = 1'b1;
        for (int i = 0; i < 8; i++) begin
            offer((i % 3 == 0) ? OP_LD : ((i % 3 == 1) ? OP_SUB : OP_OR),
                  5'(i + 10), 5'(i), 5'(i + 1), 1'b0);
            tick();
        end
        enq_valid = 1'b0;
        chk("t3_full_count", 32'(iq_count), 32'd8);
        chk("t3_full_ready", 32'(enq_ready), 32'd0);
        rob_full = 1'b0;
        for (int i = 0; i < 8; i++) begin
            offer(OP_AND, 5'(i + 20), 5'(i + 2), 5'(i + 3), 1'b0);
            tick();
        end
        enq_valid = 1'b0;
        repeat (9) tick();
        chk("t3_drained", 32'(iq_count), 32'd0);

        // Two branches: the second waits for br_commit
        offer(OP_BRANCH, 5'd17, 5'd4, 5'd5, 1'b1);
        tick();
        offer(OP_BRANCH, 5'd18, 5'd6, 5'd7, 1'b0);
        tick();
        enq_valid = 1'b0;
        repeat (3) tick();
        chk("t4_blocked", 32'(iq_count), 32'd1);
        br_commit = 1'b1;
        tick();
        br_commit = 1'b0;
        tick();
        chk("t4_released", 32'(iq_count), 32'd0);
        br_commit = 1'b1;
        tick();
        br_commit = 1'b0;

        // Mispredict flush with an enqueue offered
        rob_full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            offer(OP_ADD, 5'(i + 1), 5'd1, 5'd1, 1'b0);
            tick();
        end
        offer(OP_SUB, 5'd30, 5'd2, 5'd2, 1'b0);
        ld_pc = 1'b1;
        tick();
        ld_pc = 1'b0;
        flush_in_prog = 1'b1;
        chk("t5_count", 32'(iq_count), 32'd0);
        repeat (4) tick();
        flush_in_prog = 1'b0;
        tick();
        chk("t5_run_ready", 32'(enq_ready), 32'd1);
        enq_valid = 1'b0;
        rob_full = 1'b0;
        repeat (2) tick();

        // Asynchronous reset between edges
        rob_full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            offer(OP_OR, 5'(i + 4), 5'd2, 5'd3, 1'b0);
            tick();
        end
        enq_valid = 1'b0;
        rob_full = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("t6_async_count", 32'(iq_count), 32'd0);
        chk("t6_async_rob_load", 32'(rob_load), 32'd0);
        rst = 1'b0;
        sb.delete();
        m_run = 1'b1;
        m_br = 1'b0;
        tick();

        // Randomized traffic
        for (int i = 0; i < 150; i++) begin
            enq_valid = 1'b0;
            if ($urandom_range(0, 2) != 0)
                offer(op_t'($urandom_range(0, 7)), 5'($urandom_range(0, 31)),
                      5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                      1'($urandom_range(0, 1)));
            else
                enq_valid = 1'b0;
            rob_full      = ($urandom_range(0, 3) == 0);
            alu_rs_full   = ($urandom_range(0, 4) == 0);
            lsq_full      = ($urandom_range(0, 4) == 0);
            br_commit     = ($urandom_range(0, 5) == 0);
            ld_pc         = ($urandom_range(0, 29) == 0);
            flush_in_prog = ($urandom_range(0, 7) == 0);
            tick();
        end
        enq_valid = 1'b0; rob_full = 1'b0; alu_rs_full = 1'b0; lsq_full = 1'b0;
        ld_pc = 1'b0; flush_in_prog = 1'b0; br_commit = 1'b1;
        tick();
        br_commit = 1'b0;
        repeat (10) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
